// File: rtl/adder_rr_sched.sv
// adder_rr_sched
// Shares one two-operand AXI-Stream adder among NREQ requesters. One requester
// is granted at a time in round-robin order. Exactly two operand beats go from
// that requester to the adder, and one result beat is captured and returned to it.
// Only one operation is outstanding at a time.
//
// Handshake rule (all streams): a beat transfers on a rising CLK edge where
// TVALID and TREADY are both high. TVALID never depends on TREADY.
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   REQ_TVALID/TREADY/    per-requester operand stream; requester i data at
//   TDATA/TLAST           REQ_TDATA[i*TDATAW +: TDATAW]
//   OP_*                  operand stream to the adder (TID = grant, TDEST const)
//   RES_TVALID/TREADY/    result stream from the adder
//   TDATA
//   RSP_TVALID/TREADY     one-hot result valid / per-requester ready
//   RSP_TDATA             registered result, shared by all requesters
//   BUSY                  high whenever not arbitrating
//   GRANT_IDX             current or last granted requester
//   DONE_CNT              completed operations (wraps)
//   ERR                   sticky: requester TLAST disagreed with beat position
//   STATE_DBG             FSM state: 0 ARB, 1 FWD, 2 WAIT_RES, 3 RESP
module adder_rr_sched #(
  parameter int                NREQ       = 4,
  parameter int                TDATAW     = 32,
  parameter int                TDESTW     = 4,
  parameter int                TIDW       = 2,
  parameter logic [TDESTW-1:0] ADDER_DEST = 4'b0011,
  parameter int                CNTW       = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NREQ-1:0]        REQ_TVALID,
  output logic [NREQ-1:0]        REQ_TREADY,
  input  logic [NREQ*TDATAW-1:0] REQ_TDATA,
  input  logic [NREQ-1:0]        REQ_TLAST,
  output logic                   OP_TVALID,
  input  logic                   OP_TREADY,
  output logic [TDATAW-1:0]      OP_TDATA,
  output logic                   OP_TLAST,
  output logic [TIDW-1:0]        OP_TID,
  output logic [TDESTW-1:0]      OP_TDEST,
  input  logic                   RES_TVALID,
  output logic                   RES_TREADY,
  input  logic [TDATAW-1:0]      RES_TDATA,
  output logic [NREQ-1:0]        RSP_TVALID,
  input  logic [NREQ-1:0]        RSP_TREADY,
  output logic [TDATAW-1:0]      RSP_TDATA,
  output logic                   BUSY,
  output logic [TIDW-1:0]        GRANT_IDX,
  output logic [CNTW-1:0]        DONE_CNT,
  output logic                   ERR,
  output logic [1:0]             STATE_DBG
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ARB = 2'd0, FWD = 2'd1, WAIT_RES = 2'd2, RESP = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [TIDW-1:0]   grant_q, last_grant_q;
  logic              beat_q;
  logic [TDATAW-1:0] rsp_data_q;
  logic [CNTW-1:0]   done_cnt_q;
  logic              err_q;

  logic [IW-1:0]     gsel;
  logic              op_hs;
  logic              arb_found;
  logic [TIDW-1:0]   arb_idx;
  int                cand;

  assign gsel = IW'(grant_q);

  // Search starts one past the last completed grant, so the requester that was
  // just served has the lowest priority in the next round.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant_q) + k) % NREQ;
      if (!arb_found && REQ_TVALID[IW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = TIDW'(cand);
      end
    end
  end

  assign op_hs = (state_q == FWD) && REQ_TVALID[gsel] && OP_TREADY;

  always_comb begin
    state_d    = state_q;
    REQ_TREADY = '0;
    OP_TVALID  = 1'b0;
    RES_TREADY = 1'b0;
    RSP_TVALID = '0;
    case (state_q)
      ARB: begin
        if (arb_found) state_d = FWD;
      end
      FWD: begin
        OP_TVALID        = REQ_TVALID[gsel];
        REQ_TREADY[gsel] = OP_TREADY;
        if (op_hs && beat_q) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        RES_TREADY = 1'b1;
        if (RES_TVALID) state_d = RESP;
      end
      RESP: begin
        RSP_TVALID[gsel] = 1'b1;
        if (RSP_TREADY[gsel]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ARB;
      grant_q      <= '0;
      last_grant_q <= TIDW'(NREQ - 1);
      beat_q       <= 1'b0;
      rsp_data_q   <= '0;
      done_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ARB: begin
          if (arb_found) grant_q <= arb_idx;
        end
        FWD: begin
          if (op_hs) begin
            // Toggling also clears the counter after the second beat.
            beat_q <= ~beat_q;
            // The beat is forwarded regardless; the mismatch is only recorded.
            if (REQ_TLAST[gsel] != beat_q) err_q <= 1'b1;
          end
        end
        WAIT_RES: begin
          if (RES_TVALID) rsp_data_q <= RES_TDATA;
        end
        RESP: begin
          // Priority advances only on completion.
          if (RSP_TREADY[gsel]) begin
            last_grant_q <= grant_q;
            done_cnt_q   <= done_cnt_q + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign OP_TDATA  = REQ_TDATA[gsel*TDATAW +: TDATAW];
  assign OP_TLAST  = (state_q == FWD) && beat_q;
  assign OP_TID    = grant_q;
  assign OP_TDEST  = ADDER_DEST;
  assign RSP_TDATA = rsp_data_q;
  assign BUSY      = (state_q != ARB);
  assign GRANT_IDX = grant_q;
  assign DONE_CNT  = done_cnt_q;
  assign ERR       = err_q;
  assign STATE_DBG = state_q;

endmodule

// File: doc/adder_rr_sched.md
Name: adder_rr_sched

Overview:
Round-robin scheduler that shares one two-operand AXI-Stream adder among NREQ requesters. It grants one requester at a time and forwards exactly two operand beats to the adder. It then captures the single result beat and returns it to the granted requester. Only one operation is outstanding at a time. The block also keeps a completed-operation counter and a sticky framing-error flag.

Parameters:
NREQ, 4, number of requesters (2..16)
TDATAW, 32, operand/result data width
TDESTW, 4, TDEST width on adder operand port
TIDW, 2, TID width; must be >= clog2(NREQ)
ADDER_DEST, 4'b0011, constant driven on OP_TDEST
CNTW, 16, width of completed-operation counter

Ports:
CLK  in  1  clock
RST_N  in  1  reset, asynchronous, active-low
REQ_TVALID  in  NREQ  per-requester operand valid
REQ_TREADY  out  NREQ  per-requester operand ready
REQ_TDATA  in  NREQ*TDATAW  operands, requester i at [i*TDATAW +: TDATAW]
REQ_TLAST  in  NREQ  requester marks second operand
OP_TVALID  out  1  operand to adder
OP_TREADY  in  1  adder ready
OP_TDATA  out  TDATAW  operand data
OP_TLAST  out  1  high on second operand beat
OP_TID  out  TIDW  granted requester index
OP_TDEST  out  TDESTW  ADDER_DEST
RES_TVALID  in  1  adder result valid
RES_TREADY  out  1  result accept
RES_TDATA  in  TDATAW  adder sum
RSP_TVALID  out  NREQ  one-hot result valid toward requester
RSP_TREADY  in  NREQ  requester result ready
RSP_TDATA  out  TDATAW  registered result, shared by all requesters
BUSY  out  1  high in any state other than ARB
GRANT_IDX  out  TIDW  current or last granted index
DONE_CNT  out  CNTW  completed operations, wraps at 2^CNTW
ERR  out  1  sticky: requester TLAST disagreed with beat position

Behaviour:
- Reset values: state=ARB, last_grant=NREQ-1 (requester 0 wins first). All TVALID/TREADY outputs 0. RSP_TDATA=0, GRANT_IDX=0, DONE_CNT=0, ERR=0, beat counter=0. Reset mid-operation abandons the operation silently; no response is issued.
- States: ARB -> FWD -> WAIT_RES -> RESP -> ARB.
- ARB:
  - All REQ_TREADY=0.
  - If any REQ_TVALID is high, select the first requester with valid high searching from last_grant+1 modulo NREQ, and register it as grant.
  - Go to FWD next cycle, so arbitration costs 1 cycle.
  - No valids: stay in ARB.
- FWD:
  - Combinational pass-through: OP_TVALID=REQ_TVALID[grant], REQ_TREADY[grant]=OP_TREADY, OP_TDATA = grant's data slice. Other REQ_TREADY=0.
  - Beat counter b (0/1) increments on each OP handshake. OP_TLAST = (b==1), independent of REQ_TLAST.
  - If REQ_TLAST[grant] != (b==1) on a handshake, set ERR; the beat is still forwarded.
  - Handshake with b==1: go to WAIT_RES and clear b. The grant is held for both beats; other requesters are never interleaved.
- WAIT_RES:
  - RES_TREADY=1.
  - On RES_TVALID: RSP_TDATA <= RES_TDATA, go to RESP.
  - RES_TVALID in any other state is ignored (RES_TREADY=0).
- RESP:
  - RSP_TVALID[grant]=1; all other bits 0. RSP_TDATA holds stable.
  - On RSP_TREADY[grant]: last_grant <= grant, DONE_CNT += 1 (wraps), go to ARB.
- Round-robin is updated only on completion, so a requester stalled in RESP keeps priority position unchanged.
- Requester dropping TVALID mid-packet: the grant is held in FWD indefinitely until the second beat; no timeout.
- Arithmetic is entirely in the adder; the block does not modify data.
- Minimum turnaround with a zero-stall adder and requester: 1 (ARB) + 2 (FWD) + adder latency + 1 (WAIT_RES capture) + 1 (RESP) cycles.

Test Plan:
- Single requester 1 sends 5, then 7 (TLAST on 7) -> OP_TID=1, OP_TLAST only on beat 2. RSP_TVALID=4'b0010 with RSP_TDATA=12, then DONE_CNT=1.
- All 4 requesters continuously valid -> grant order 0,1,2,3,0. Each result correct (e.g. req i sends i,100 -> 100+i).
- Requester 2 sends TLAST on first beat (values 3,4) -> ERR=1 and stays 1. Result 7 is still returned to requester 2.
- Requester 0 holds RSP_TREADY low 10 cycles while requester 1 is valid -> requester 1 is not granted until RSP handshake. RSP_TDATA is stable throughout.
- OP_TREADY toggled 1/0 every cycle and RES_TVALID delayed 5 cycles -> no beat lost or duplicated. Sum 0xFFFFFFFF+1 returns 0.
- Assert RST_N low during WAIT_RES -> all outputs return to reset values. Next grant goes to requester 0. DONE_CNT=0.
